scoreboard_ctrl: RTL and testbench

Register-hazard scoreboard that tracks in-flight writes to architectural registers and gates instruction issue. The scheduler marks a destination register busy when an instruction issues. The writeback stage releases it through its scoreboard clear address/valid pair. Issue readiness is withheld on read-after-write hazards or counter saturation. It sits between the issue/scheduler logic and the writeback stage, on the receiving end of the writeback stage's scoreboard-clear outputs.

---
 rtl/scoreboard_ctrl.sv | 129 ++++++++++++
 tb/tb_scoreboard_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_ctrl.sv
// scoreboard_ctrl: register-hazard scoreboard gating instruction issue.
// Ports: clk, rst_n (async active-low); issue_* from the scheduler,
//   issue_ready_o back to it; clear_valid_i/clear_rd_i from writeback;
//   flush_i; busy_vector_o (counter n non-zero); underflow_err_o (sticky).
// Optional: define SCOREBOARD_BYPASS_EN to let a same-cycle writeback
//   clear resolve a hazard combinationally.
module scoreboard_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid_i,
    input  logic [4:0]          issue_rd_i,
    input  logic                issue_reg_write_i,
    input  logic [4:0]          issue_rs1_i,
    input  logic [4:0]          issue_rs2_i,
    input  logic                issue_rs1_used_i,
    input  logic                issue_rs2_used_i,
    output logic                issue_ready_o,
    input  logic                clear_valid_i,
    input  logic [4:0]          clear_rd_i,
    input  logic                flush_i,
    output logic [NUM_REGS-1:0] busy_vector_o,
    output logic                underflow_err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic             uf_q;

    logic [CNT_W-1:0] rs1_cnt;
    logic [CNT_W-1:0] rs2_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] clr_cnt;
    logic             clr_hit;
    logic             rs1_free;
    logic             rs2_free;
    logic             rd_free;
    logic             rs1_haz;
    logic             rs2_haz;
    logic             sat;
    logic             ready;
    logic             inc;
    logic             same_reg;

    // Address-to-counter muxes; addresses beyond NUM_REGS and
    // register 0 read as zero.
    always_comb begin
        rs1_cnt = '0;
        rs2_cnt = '0;
        rd_cnt  = '0;
        clr_cnt = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (issue_rs1_i == 5'(i)) rs1_cnt = cnt[i];
            if (issue_rs2_i == 5'(i)) rs2_cnt = cnt[i];
            if (issue_rd_i  == 5'(i)) rd_cnt  = cnt[i];
            if (clear_rd_i  == 5'(i)) clr_cnt = cnt[i];
        end
    end

    assign clr_hit = clear_valid_i && (clear_rd_i != 5'd0);

`ifdef SCOREBOARD_BYPASS_EN
    // Last outstanding write retiring this cycle frees the source;
    // any clear of rd frees one slot for the saturation check.
    assign rs1_free = clr_hit && (clear_rd_i == issue_rs1_i)
                      && (rs1_cnt == CNT_ONE);
    assign rs2_free = clr_hit && (clear_rd_i == issue_rs2_i)
                      && (rs2_cnt == CNT_ONE);
    assign rd_free  = clr_hit && (clear_rd_i == issue_rd_i);
`else
    assign rs1_free = 1'b0;
    assign rs2_free = 1'b0;
    assign rd_free  = 1'b0;
`endif

    assign rs1_haz = issue_rs1_used_i && (issue_rs1_i != 5'd0)
                     && (rs1_cnt != '0) && !rs1_free;
    assign rs2_haz = issue_rs2_used_i && (issue_rs2_i != 5'd0)
                     && (rs2_cnt != '0) && !rs2_free;
    assign sat     = issue_reg_write_i && (rd_cnt == CNT_MAX) && !rd_free;

    assign ready = !flush_i && !rs1_haz && !rs2_haz && !sat;
    assign inc   = issue_valid_i && ready && issue_reg_write_i
                   && (issue_rd_i != 5'd0);

    // A matching increment cancels the clear, so no underflow then.
    assign same_reg = inc && (issue_rd_i == clear_rd_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
            uf_q <= 1'b0;
        end else begin
            cnt[0] <= '0;
            if (flush_i) begin
                for (int i = 1; i < NUM_REGS; i++) cnt[i] <= '0;
            end else begin
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (inc && (issue_rd_i == 5'(i))
                        && !(clr_hit && (clear_rd_i == 5'(i)))) begin
                        cnt[i] <= cnt[i] + CNT_ONE;
                    end else if (clr_hit && (clear_rd_i == 5'(i))
                                 && !(inc && (issue_rd_i == 5'(i)))
                                 && (cnt[i] != '0)) begin
                        cnt[i] <= cnt[i] - CNT_ONE;
                    end
                end
                if (clr_hit && (clr_cnt == '0) && !same_reg) begin
                    uf_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy_vector_o = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            busy_vector_o[i] = (cnt[i] != '0);
        end
    end

    assign issue_ready_o   = ready;
    assign underflow_err_o = uf_q;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// tb_scoreboard_ctrl: directed bench for scoreboard_ctrl.
// Expected ready/busy/underflow values are queued per step and popped at sample.
module tb_scoreboard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_reg_write;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_rs1_used;
    logic        issue_rs2_used;
    logic        issue_ready;
    logic        clear_valid;
    logic [4:0]  clear_rd;
    logic        flush;
    logic [31:0] busy_vector;
    logic        underflow_err;

    int checks   = 0;
    int failures = 0;

`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } ent_t;

    ent_t rdy_q[$];
    ent_t st_q[$];

    always #5 clk = ~clk;

    scoreboard_ctrl #(.NUM_REGS(32), .CNT_W(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .issue_valid_i    (issue_valid),
        .issue_rd_i       (issue_rd),
        .issue_reg_write_i(issue_reg_write),
        .issue_rs1_i      (issue_rs1),
        .issue_rs2_i      (issue_rs2),
        .issue_rs1_used_i (issue_rs1_used),
        .issue_rs2_used_i (issue_rs2_used),
        .issue_ready_o    (issue_ready),
        .clear_valid_i    (clear_valid),
        .clear_rd_i       (clear_rd),
        .flush_i          (flush),
        .busy_vector_o    (busy_vector),
        .underflow_err_o  (underflow_err)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid     = 1'b0;
        issue_rd        = 5'd0;
        issue_reg_write = 1'b0;
        issue_rs1       = 5'd0;
        issue_rs2       = 5'd0;
        issue_rs1_used  = 1'b0;
        issue_rs2_used  = 1'b0;
        clear_valid     = 1'b0;
        clear_rd        = 5'd0;
        flush           = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic wr);
        issue_valid     = 1'b1;
        issue_rd        = rd;
        issue_reg_write = wr;
    endtask

    task automatic clr(input logic [4:0] rd);
        clear_valid = 1'b1;
        clear_rd    = rd;
    endtask

    // Push expectations, then pop and compare when the DUT presents them:
    // ready before the edge, busy/underflow just after it.
    task automatic step(input string tag, input logic rdy,
                        input logic [31:0] busy, input logic uf);
        ent_t e;
        rdy_q.push_back('{{tag, ".ready"}, {31'd0, rdy}});
        st_q.push_back('{{tag, ".busy"}, busy});
        st_q.push_back('{{tag, ".uf"}, {31'd0, uf}});
        @(negedge clk);
        e = rdy_q.pop_front();
        check(e.tag, {31'd0, issue_ready}, e.exp);
        @(posedge clk);
        #1;
        e = st_q.pop_front();
        check(e.tag, busy_vector, e.exp);
        e = st_q.pop_front();
        check(e.tag, {31'd0, underflow_err}, e.exp);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #12;
        check("rst.busy", busy_vector, 32'h0);
        check("rst.uf", {31'd0, underflow_err}, 32'h0);
        check("rst.ready", {31'd0, issue_ready}, 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic RAW on r5
        issue(5'd5, 1'b1);
        step("iss5", 1'b1, 32'h20, 1'b0);
        idle();
        issue(5'd1, 1'b0);
        issue_rs1 = 5'd5;
        issue_rs1_used = 1'b1;
        step("raw5", 1'b0, 32'h20, 1'b0);
        clr(5'd5);
        step("clr5", BYP, 32'h0, 1'b0);
        clear_valid = 1'b0;
        step("after5", 1'b1, 32'h0, 1'b0);

        // r0 is never tracked
        idle();
        for (int k = 0; k < 3; k++) begin
            issue(5'd0, 1'b1);
            step("iss0", 1'b1, 32'h0, 1'b0);
        end
        idle();
        clr(5'd0);
        step("clr0", 1'b1, 32'h0, 1'b0);

        // Saturation on r7
        idle();
        for (int k = 0; k < 3; k++) begin
            issue(5'd7, 1'b1);
            step("iss7", 1'b1, 32'h80, 1'b0);
        end
        step("sat7", 1'b0, 32'h80, 1'b0);
        clr(5'd7);
        step("sat7clr", BYP, 32'h80, 1'b0);
        clear_valid = 1'b0;
        step("sat7retry", !BYP, 32'h80, 1'b0);
        idle();
        clr(5'd7);
        step("drain7a", 1'b1, 32'h80, 1'b0);
        step("drain7b", 1'b1, 32'h80, 1'b0);
        step("drain7c", 1'b1, 32'h0, 1'b0);

        // Same-register inc/dec on r9, plus rs2 hazard
        idle();
        issue(5'd9, 1'b1);
        step("iss9", 1'b1, 32'h200, 1'b0);
        clr(5'd9);
        step("incdec9", 1'b1, 32'h200, 1'b0);
        idle();
        issue(5'd1, 1'b0);
        issue_rs2 = 5'd9;
        issue_rs2_used = 1'b1;
        step("raw9rs2", 1'b0, 32'h200, 1'b0);
        idle();
        clr(5'd9);
        step("clr9", 1'b1, 32'h0, 1'b0);

        // Flush drops everything, ignores same-cycle issue
        idle();
        issue(5'd3, 1'b1);
        step("iss3", 1'b1, 32'h8, 1'b0);
        issue(5'd4, 1'b1);
        step("iss4", 1'b1, 32'h18, 1'b0);
        issue(5'd6, 1'b1);
        flush = 1'b1;
        step("flush", 1'b0, 32'h0, 1'b0);
        idle();
        step("postflush", 1'b1, 32'h0, 1'b0);

        // Underflow and async reset
        issue(5'd2, 1'b1);
        step("iss2", 1'b1, 32'h4, 1'b0);
        idle();
        clr(5'd12);
        step("uf12", 1'b1, 32'h4, 1'b1);
        idle();
        step("ufsticky", 1'b1, 32'h4, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.busy", busy_vector, 32'h0);
        check("arst.uf", {31'd0, underflow_err}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("arst.after", 1'b1, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
